wfq_rank_calc: RTL and testbench

Parametrised weighted-fair-queueing rank calculator for the PIFO scheduler datapath. For each packet tuple (egress port, class, packet size) it computes a start-time-fair-queueing rank, `max(flow finish round, port virtual round)`, and emits it to the PIFO. It then advances the flow's finish round by `size / weight`, using a multi-cycle restoring divider. A single-clock control port reads and writes per-flow weights and reads back per-flow rounds.

---
 rtl/wfq_rank_calc.sv | 195 +++++++++++++++++++
 tb/tb_wfq_rank_calc.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfq_rank_calc.sv
// Start-time fair queueing rank calculator: rank = max(flow finish, port vtime), then finish += size/weight.
// Optional `define WFQ_REMAINDER_CARRY_EN keeps the per-flow division remainder for the next packet.
module wfq_rank_calc #(
    parameter int NUM_PORTS      = 5,
    parameter int PORT_WIDTH     = 8,
    parameter int CLASS_WIDTH    = 5,
    parameter int PKT_SIZE_WIDTH = 11,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int ROUND_WIDTH    = 20,
    parameter int PORT_ID_WIDTH  = $clog2(NUM_PORTS),
    parameter int FLOW_ID_WIDTH  = PORT_ID_WIDTH + CLASS_WIDTH
) (
    input  logic                                         clk_dp,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [PKT_SIZE_WIDTH+PORT_WIDTH+CLASS_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS*ROUND_WIDTH-1:0]             vtime,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [FLOW_ID_WIDTH+ROUND_WIDTH-1:0]         out_data,
    input  logic                                         cfg_valid,
    input  logic                                         cfg_write,
    input  logic [FLOW_ID_WIDTH-1:0]                     cfg_index,
    input  logic [WEIGHT_WIDTH-1:0]                      cfg_wdata,
    output logic                                         cfg_rvalid,
    output logic [ROUND_WIDTH+WEIGHT_WIDTH-1:0]          cfg_rdata
);
    localparam int NUM_FLOWS = NUM_PORTS << CLASS_WIDTH;
`ifdef WFQ_REMAINDER_CARRY_EN
    localparam int DIV_WIDTH = PKT_SIZE_WIDTH + 1;
`else
    localparam int DIV_WIDTH = PKT_SIZE_WIDTH;
`endif
    localparam int CNT_WIDTH = $clog2(DIV_WIDTH);
    localparam logic [ROUND_WIDTH-1:0]   ROUND_MAX   = '1;
    localparam logic [FLOW_ID_WIDTH:0]   NUM_FLOWS_W = (FLOW_ID_WIDTH+1)'(NUM_FLOWS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DIV, S_UPDATE, S_OUT} state_t;

    state_t                    state;
    logic [PKT_SIZE_WIDTH-1:0] size_r;
    logic [PORT_ID_WIDTH-1:0]  port_id_r;
    logic [CLASS_WIDTH-1:0]    class_r;
    logic [WEIGHT_WIDTH-1:0]   w_r;
    logic                      w_zero_r;
    logic [ROUND_WIDTH-1:0]    start_r;
    logic [DIV_WIDTH-1:0]      quo_r;
    logic [WEIGHT_WIDTH-1:0]   rem_acc;
    logic [CNT_WIDTH-1:0]      cnt;

    logic [ROUND_WIDTH-1:0]    finish_tbl [NUM_FLOWS];
    logic [WEIGHT_WIDTH-1:0]   weight_tbl [NUM_FLOWS];
`ifdef WFQ_REMAINDER_CARRY_EN
    logic [PKT_SIZE_WIDTH-1:0] rem_tbl    [NUM_FLOWS];
`endif

    logic [PKT_SIZE_WIDTH-1:0] in_size;
    logic [PORT_WIDTH-1:0]     in_port;
    logic [CLASS_WIDTH-1:0]    in_class;
    logic [PORT_ID_WIDTH-1:0]  dec_port_id;
    logic [FLOW_ID_WIDTH-1:0]  flow_r;
    logic [ROUND_WIDTH-1:0]    f_cur;
    logic [ROUND_WIDTH-1:0]    v_cur;
    logic [DIV_WIDTH-1:0]      dividend;
    logic [WEIGHT_WIDTH:0]     trial;
    logic                      div_ge;
    logic [WEIGHT_WIDTH-1:0]   rem_next;
    logic [ROUND_WIDTH-1:0]    q_ext;
    logic [ROUND_WIDTH:0]      sum;
    logic [ROUND_WIDTH-1:0]    new_finish;
    logic                      cfg_in_range;

    assign {in_size, in_port, in_class} = in_data;
    assign flow_r       = {port_id_r, class_r};
    assign f_cur        = finish_tbl[flow_r];
    assign v_cur        = vtime[port_id_r*ROUND_WIDTH +: ROUND_WIDTH];
    assign cfg_in_range = {1'b0, cfg_index} < NUM_FLOWS_W;

`ifdef WFQ_REMAINDER_CARRY_EN
    assign dividend = DIV_WIDTH'(size_r) + DIV_WIDTH'(rem_tbl[flow_r]);
`else
    assign dividend = size_r;
`endif

    // One restoring step: bring down the next dividend bit and subtract if it fits.
    assign trial    = {rem_acc, quo_r[DIV_WIDTH-1]};
    assign div_ge   = trial >= {1'b0, w_r};
    assign rem_next = div_ge ? WEIGHT_WIDTH'(trial - {1'b0, w_r}) : trial[WEIGHT_WIDTH-1:0];

    assign q_ext      = w_zero_r ? ROUND_MAX : ROUND_WIDTH'(quo_r);
    assign sum        = {1'b0, start_r} + {1'b0, q_ext};
    assign new_finish = sum[ROUND_WIDTH] ? ROUND_MAX : sum[ROUND_WIDTH-1:0];

    // NOTE: the default before the loop is what keeps this block free of inferred latches.
    always_comb begin
        dec_port_id = PORT_ID_WIDTH'(NUM_PORTS - 1);
        for (int k = 0; k < NUM_PORTS - 1; k++) begin
            if (2*k < PORT_WIDTH && in_port == (PORT_WIDTH'(1) << (2*k)))
                dec_port_id = PORT_ID_WIDTH'(k);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            size_r    <= '0;
            port_id_r <= '0;
            class_r   <= '0;
            w_r       <= '0;
            w_zero_r  <= 1'b0;
            start_r   <= '0;
            quo_r     <= '0;
            rem_acc   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        size_r    <= in_size;
                        port_id_r <= dec_port_id;
                        class_r   <= in_class;
                        in_ready  <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    w_r      <= weight_tbl[flow_r];
                    w_zero_r <= (weight_tbl[flow_r] == '0);
                    start_r  <= (f_cur >= v_cur) ? f_cur : v_cur;
                    quo_r    <= dividend;
                    rem_acc  <= '0;
                    cnt      <= '0;
                    state    <= (weight_tbl[flow_r] == '0) ? S_UPDATE : S_DIV;
                end
                S_DIV: begin
                    quo_r   <= {quo_r[DIV_WIDTH-2:0], div_ge};
                    rem_acc <= rem_next;
                    cnt     <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(DIV_WIDTH - 1))
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    out_valid <= 1'b1;
                    out_data  <= {flow_r, start_r};
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the flow tables are register arrays and must clear on reset, so they are reset explicitly.
    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                finish_tbl[i] <= '0;
                weight_tbl[i] <= '0;
`ifdef WFQ_REMAINDER_CARRY_EN
                rem_tbl[i]    <= '0;
`endif
            end
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            cfg_rvalid <= cfg_valid;
            if (cfg_valid)
                cfg_rdata <= cfg_in_range ? {finish_tbl[cfg_index], weight_tbl[cfg_index]} : '0;
            if (state == S_UPDATE) begin
                finish_tbl[flow_r] <= new_finish;
`ifdef WFQ_REMAINDER_CARRY_EN
                rem_tbl[flow_r]    <= PKT_SIZE_WIDTH'(rem_acc);
`endif
            end
            if (cfg_valid && cfg_write && cfg_in_range) begin
                weight_tbl[cfg_index] <= cfg_wdata;
`ifdef WFQ_REMAINDER_CARRY_EN
                rem_tbl[cfg_index]    <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_wfq_rank_calc.sv
// Self-checking bench for wfq_rank_calc: behavioural flow-table model, per-cycle output compare, randomized traffic.
module tb_wfq_rank_calc;
    localparam int NUM_PORTS      = 5;
    localparam int PORT_WIDTH     = 8;
    localparam int CLASS_WIDTH    = 5;
    localparam int PKT_SIZE_WIDTH = 11;
    localparam int WEIGHT_WIDTH   = 8;
    localparam int ROUND_WIDTH    = 20;
    localparam int PORT_ID_WIDTH  = $clog2(NUM_PORTS);
    localparam int FLOW_ID_WIDTH  = PORT_ID_WIDTH + CLASS_WIDTH;
    localparam int NUM_FLOWS      = NUM_PORTS << CLASS_WIDTH;
    localparam int ROUND_MAX      = (1 << ROUND_WIDTH) - 1;
`ifdef WFQ_REMAINDER_CARRY_EN
    localparam bit CARRY   = 1'b1;
    localparam int LAT_DIV = PKT_SIZE_WIDTH + 4;
`else
    localparam bit CARRY   = 1'b0;
    localparam int LAT_DIV = PKT_SIZE_WIDTH + 3;
`endif
    localparam int LAT_W0 = 3;

    logic                                           clk_dp = 1'b0;
    logic                                           rst = 1'b0;
    logic                                           in_valid = 1'b0;
    logic                                           in_ready;
    logic [PKT_SIZE_WIDTH+PORT_WIDTH+CLASS_WIDTH-1:0] in_data = '0;
    logic [NUM_PORTS*ROUND_WIDTH-1:0]               vtime = '0;
    logic                                           out_valid;
    logic                                           out_ready = 1'b1;
    logic [FLOW_ID_WIDTH+ROUND_WIDTH-1:0]           out_data;
    logic                                           cfg_valid = 1'b0;
    logic                                           cfg_write = 1'b0;
    logic [FLOW_ID_WIDTH-1:0]                       cfg_index = '0;
    logic [WEIGHT_WIDTH-1:0]                        cfg_wdata = '0;
    logic                                           cfg_rvalid;
    logic [ROUND_WIDTH+WEIGHT_WIDTH-1:0]            cfg_rdata;

    wfq_rank_calc dut (
        .clk_dp    (clk_dp),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .vtime     (vtime),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_write (cfg_write),
        .cfg_index (cfg_index),
        .cfg_wdata (cfg_wdata),
        .cfg_rvalid(cfg_rvalid),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clk_dp = ~clk_dp;

    int cyc = 0;
    always @(posedge clk_dp) cyc <= cyc + 1;

    // Behavioural flow-table model.
    int fin_m [NUM_FLOWS];
    int wt_m  [NUM_FLOWS];
    int rem_m [NUM_FLOWS];
    int vt_m  [NUM_PORTS];

    typedef struct { int flow; int rank; int lat; } exp_pkt_t;
    typedef struct { int fin; int wt; } exp_cfg_t;
    exp_pkt_t pkt_q[$];
    exp_cfg_t cfg_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cyc = 0;
    int last_rank = -1;
    int last_lat = -1;
    int last_cfg_fin = -1;
    int last_cfg_wt = -1;
    bit pre_update = 1'b0;
    int act_flow = -1;
    int act_old = 0;
    bit rand_ready = 1'b0;
    bit prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic int port_of(input logic [PORT_WIDTH-1:0] p);
        for (int k = 0; k < NUM_PORTS - 1; k++)
            if (2*k < PORT_WIDTH && p == (PORT_WIDTH'(1) << (2*k))) return k;
        return NUM_PORTS - 1;
    endfunction

    task automatic tick();
        @(posedge clk_dp);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FLOWS; i++) begin
            fin_m[i] = 0;
            wt_m[i]  = 0;
            rem_m[i] = 0;
        end
        pkt_q.delete();
        cfg_q.delete();
        pre_update = 1'b0;
    endtask

    task automatic set_vtime(input int p, input int val);
        vt_m[p] = val;
        vtime[p*ROUND_WIDTH +: ROUND_WIDTH] = ROUND_WIDTH'(val);
    endtask

    task automatic send_pkt(input logic [PORT_WIDTH-1:0] port, input int cls, input int size);
        int n, pid, flow, start, q, d, w;
        n = 0;
        while (!in_ready) begin
            tick();
            if (++n > 300) begin timeout_fail("in_ready wait"); return; end
        end
        in_data  = {PKT_SIZE_WIDTH'(size), port, CLASS_WIDTH'(cls)};
        in_valid = 1'b1;
        pid   = port_of(port);
        flow  = (pid << CLASS_WIDTH) + cls;
        start = (fin_m[flow] > vt_m[pid]) ? fin_m[flow] : vt_m[pid];
        w     = wt_m[flow];
        act_flow   = flow;
        act_old    = fin_m[flow];
        pre_update = 1'b1;
        if (w == 0) begin
            q = ROUND_MAX;
            rem_m[flow] = 0;
            pkt_q.push_back('{flow, start, LAT_W0});
        end else begin
            d = size + (CARRY ? rem_m[flow] : 0);
            q = d / w;
            rem_m[flow] = d % w;
            pkt_q.push_back('{flow, start, LAT_DIV});
        end
        fin_m[flow] = (start + q > ROUND_MAX) ? ROUND_MAX : start + q;
        tick();
        in_valid = 1'b0;
        hs_cyc   = cyc;
    endtask

    task automatic cfg_op(input bit wr, input int idx, input int wdata);
        int fin;
        cfg_valid = 1'b1;
        cfg_write = wr;
        cfg_index = FLOW_ID_WIDTH'(idx);
        cfg_wdata = WEIGHT_WIDTH'(wdata);
        fin = (pre_update && idx == act_flow) ? act_old : fin_m[idx];
        cfg_q.push_back('{fin, wt_m[idx]});
        if (wr) begin
            wt_m[idx]  = wdata;
            rem_m[idx] = 0;
        end
        tick();
        cfg_valid = 1'b0;
        cfg_write = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pkt_q.size() != 0 || !in_ready) begin
            tick();
            if (++n > 400) begin timeout_fail("idle wait"); return; end
        end
    endtask

    task automatic wait_cfg();
        int n = 0;
        while (cfg_q.size() != 0) begin
            tick();
            if (++n > 20) begin timeout_fail("cfg response wait"); return; end
        end
    endtask

    // Compare process: every cycle the outputs carry meaning, against the model's expectations.
    always @(negedge clk_dp) begin
        if (rst) begin
            if (out_valid) begin
                if (pkt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected out_valid: out_data=%0h", out_data);
                end else begin
                    check("out flow", 64'(out_data[FLOW_ID_WIDTH+ROUND_WIDTH-1:ROUND_WIDTH]), pkt_q[0].flow);
                    check("out rank", 64'(out_data[ROUND_WIDTH-1:0]), pkt_q[0].rank);
                    if (!prev_valid) begin
                        last_lat = cyc + 1 - hs_cyc;
                        check("latency", last_lat, pkt_q[0].lat);
                        pre_update = 1'b0;
                    end
                    if (out_ready) begin
                        last_rank = int'(out_data[ROUND_WIDTH-1:0]);
                        void'(pkt_q.pop_front());
                    end
                end
            end
            if (cfg_rvalid) begin
                if (cfg_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected cfg_rvalid: cfg_rdata=%0h", cfg_rdata);
                end else begin
                    last_cfg_fin = int'(cfg_rdata[ROUND_WIDTH+WEIGHT_WIDTH-1:WEIGHT_WIDTH]);
                    last_cfg_wt  = int'(cfg_rdata[WEIGHT_WIDTH-1:0]);
                    check("cfg finish", last_cfg_fin, cfg_q[0].fin);
                    check("cfg weight", last_cfg_wt, cfg_q[0].wt);
                    void'(cfg_q.pop_front());
                end
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #400000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [PORT_WIDTH-1:0] rand_port_code(input int k);
        if (k < NUM_PORTS - 1) return PORT_WIDTH'(1) << (2*k);
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'h02;
            2:       return 8'h81;
            3:       return 8'hFF;
            default: return 8'h50;
        endcase
    endfunction

    initial begin
        model_reset();
        for (int p = 0; p < NUM_PORTS; p++) vt_m[p] = 0;

        // Reset state.
        repeat (3) tick();
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset cfg_rvalid", cfg_rvalid, 0);
        check("reset cfg_rdata", cfg_rdata, 0);
        rst = 1'b1;
        tick();
        check("in_ready after release", in_ready, 1);

        // Flow {0,3}, weight 4: ranks 0, 25; finish 50.
        cfg_op(1, 3, 4);
        send_pkt(8'h01, 3, 100);
        wait_idle();
        check("pin rank pkt1", last_rank, 0);
        send_pkt(8'h01, 3, 100);
        wait_idle();
        check("pin rank pkt2", last_rank, 25);
        cfg_op(0, 3, 0);
        wait_cfg();
        check("pin finish 50", last_cfg_fin, 50);

        // Port 0 vtime 60: rank 60, finish 85.
        set_vtime(0, 60);
        send_pkt(8'h01, 3, 100);
        wait_idle();
        check("pin rank vtime", last_rank, 60);
        cfg_op(0, 3, 0);
        wait_cfg();
        check("pin finish 85", last_cfg_fin, 85);

        // Weight 0 on flow {1,0}: rank 0 in 3 cycles, then saturated rank.
        cfg_op(1, 1 << CLASS_WIDTH, 0);
        send_pkt(8'h04, 0, 64);
        wait_idle();
        check("pin w0 rank", last_rank, 0);
        check("pin w0 latency", last_lat, 3);
        send_pkt(8'h04, 0, 64);
        wait_idle();
        check("pin w0 saturated", last_rank, 1048575);

        // Weight 4, three 10 B packets on flow {2,7}.
        cfg_op(1, (2 << CLASS_WIDTH) + 7, 4);
        send_pkt(8'h10, 7, 10);
        wait_idle();
        check("pin small rank0", last_rank, 0);
        send_pkt(8'h10, 7, 10);
        wait_idle();
        check("pin small rank1", last_rank, 2);
        send_pkt(8'h10, 7, 10);
        wait_idle();
        check("pin small rank2", last_rank, CARRY ? 5 : 4);

        // Output back-pressure for 20 cycles.
        cfg_op(1, (3 << CLASS_WIDTH) + 1, 5);
        out_ready = 1'b0;
        send_pkt(8'h40, 1, 50);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin tick(); n++; end
            if (!out_valid) timeout_fail("out_valid wait");
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            check("in_ready while stalled", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("in_ready after release", in_ready, 1);
        wait_idle();

        // Weight write mid-DIV on the active flow {0,3}.
        send_pkt(8'h01, 3, 100);
        repeat (4) tick();
        cfg_op(1, 3, 10);
        wait_idle();
        wait_cfg();
        check("pin midDIV rank", last_rank, 85);
        check("pin midDIV old finish", last_cfg_fin, 85);
        check("pin midDIV old weight", last_cfg_wt, 4);
        send_pkt(8'h01, 3, 100);
        wait_idle();
        check("pin new weight rank", last_rank, 110);
        cfg_op(0, 3, 0);
        wait_cfg();
        check("pin new weight finish", last_cfg_fin, 120);

        // Reset pulse during DIV.
        send_pkt(8'h01, 3, 100);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst cfg_rvalid", cfg_rvalid, 0);
        check("rst cfg_rdata", cfg_rdata, 0);
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        check("in_ready after pulse", in_ready, 1);
        cfg_op(0, 3, 0);
        wait_cfg();
        check("pin flow cleared finish", last_cfg_fin, 0);
        check("pin flow cleared weight", last_cfg_wt, 0);

        // Randomized traffic over a small flow pool.
        for (int k = 0; k < NUM_PORTS; k++)
            for (int c = 0; c < 4; c++)
                cfg_op(1, (k << CLASS_WIDTH) + c, $urandom_range(1, 16));
        rand_ready = 1'b1;
        for (int it = 0; it < 120; it++) begin
            int r, k, c;
            r = $urandom_range(0, 9);
            k = $urandom_range(0, NUM_PORTS - 1);
            c = $urandom_range(0, 3);
            if (r <= 5) begin
                send_pkt(rand_port_code(k), c, $urandom_range(0, (1 << PKT_SIZE_WIDTH) - 1));
            end else if (r <= 7) begin
                wait_idle();
                cfg_op(1, (k << CLASS_WIDTH) + c,
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << WEIGHT_WIDTH) - 1));
            end else if (r == 8) begin
                wait_idle();
                cfg_op(0, (k << CLASS_WIDTH) + c, 0);
            end else begin
                wait_idle();
                set_vtime(k, $urandom_range(0, 4000));
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_idle();
        wait_cfg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
